// File: rtl/regfile_write_arbiter.sv
// Register file write arbiter.
// Three requesters each own a one-entry holding buffer. One buffered write is
// drained to the register file array per cycle, chosen by round-robin or
// fixed priority. Acceptance is blocked whenever it could reorder writes to
// the same register, so at most one buffered entry exists per register.
module regfile_write_arbiter #(
    parameter bit DROP_R0    = 1'b1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    output logic [2:0]  req_ready,
    input  logic [4:0]  req_wnum0,
    input  logic [4:0]  req_wnum1,
    input  logic [4:0]  req_wnum2,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    input  logic [31:0] req_wdata2,
    output logic        rf_write,
    output logic [4:0]  rf_wnum,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending_mask,
    output logic [1:0]  grant_id
);

    // Requester inputs gathered into arrays so the per-requester logic can loop.
    logic [4:0]  req_wnum  [3];
    logic [31:0] req_wdata [3];

    assign req_wnum[0]  = req_wnum0;
    assign req_wnum[1]  = req_wnum1;
    assign req_wnum[2]  = req_wnum2;
    assign req_wdata[0] = req_wdata0;
    assign req_wdata[1] = req_wdata1;
    assign req_wdata[2] = req_wdata2;

    // Holding buffers and round-robin pointer.
    logic [2:0]  buf_valid_q, buf_valid_d;
    logic [4:0]  buf_wnum_q  [3];
    logic [4:0]  buf_wnum_d  [3];
    logic [31:0] buf_wdata_q [3];
    logic [31:0] buf_wdata_d [3];
    logic [1:0]  last_grant_q, last_grant_d;

    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [2:0]  drain;
    logic [1:0]  rr_start;
    logic [2:0]  rr_sum;
    logic [2:0]  xfer;

    // Select at most one valid buffer to drain this cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd3;
        rr_start    = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
        rr_sum      = 3'd0;
        if (FIXED_PRIO) begin
            // Descending scan: the last hit is the lowest index.
            for (int i = 2; i >= 0; i--) begin
                if (buf_valid_q[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = 2'(i);
                end
            end
        end else begin
            // Descending offset scan: the last hit is nearest to rr_start.
            for (int k = 2; k >= 0; k--) begin
                rr_sum = {1'b0, rr_start} + 3'(k);
                if (rr_sum >= 3'd3) begin
                    rr_sum = rr_sum - 3'd3;
                end
                if (buf_valid_q[rr_sum[1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_sum[1:0];
                end
            end
        end
    end

    // One-hot view of the buffer being drained.
    always_comb begin
        drain = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (grant_valid && (grant_idx == 2'(i))) begin
                drain[i] = 1'b1;
            end
        end
    end

    // Drive the array write port straight from the granted buffer.
    always_comb begin
        rf_write = grant_valid;
        rf_wnum  = 5'd0;
        rf_wdata = 32'd0;
        grant_id = grant_idx;
        for (int i = 0; i < 3; i++) begin
            if (drain[i]) begin
                rf_wnum  = buf_wnum_q[i];
                rf_wdata = buf_wdata_q[i];
            end
        end
    end

    // Acceptance: free slot, no pending write to the same register elsewhere,
    // and no lower-index requester racing for the same register this cycle.
    always_comb begin
        req_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            logic slot_free;
            logic conflict;
            slot_free = ~buf_valid_q[i] | drain[i];
            conflict  = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if ((j != i) && buf_valid_q[j] && !drain[j] &&
                    (buf_wnum_q[j] == req_wnum[i])) begin
                    conflict = 1'b1;
                end
                if ((j < i) && req_valid[j] && (req_wnum[j] == req_wnum[i])) begin
                    conflict = 1'b1;
                end
            end
            req_ready[i] = reset & slot_free & ~conflict;
        end
    end

    assign xfer = req_valid & req_ready;

    // Outstanding-register view of the buffer contents.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < 3; i++) begin
            if (buf_valid_q[i]) begin
                pending_mask = pending_mask | (32'd1 << buf_wnum_q[i]);
            end
        end
    end

    // Next buffer state: a refill wins over a drain on the same edge.
    always_comb begin
        buf_valid_d  = buf_valid_q;
        last_grant_d = grant_valid ? grant_idx : last_grant_q;
        for (int i = 0; i < 3; i++) begin
            buf_wnum_d[i]  = buf_wnum_q[i];
            buf_wdata_d[i] = buf_wdata_q[i];
            if (xfer[i]) begin
                // Writes to r0 complete the handshake but are never buffered.
                if (DROP_R0 && (req_wnum[i] == 5'd0)) begin
                    buf_valid_d[i] = 1'b0;
                end else begin
                    buf_valid_d[i] = 1'b1;
                    buf_wnum_d[i]  = req_wnum[i];
                    buf_wdata_d[i] = req_wdata[i];
                end
            end else if (drain[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
    end

    // State registers; last_grant resets to 2 so requester 0 is favoured first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid_q  <= 3'b000;
            last_grant_q <= 2'd2;
            for (int i = 0; i < 3; i++) begin
                buf_wnum_q[i]  <= 5'd0;
                buf_wdata_q[i] <= 32'd0;
            end
        end else begin
            buf_valid_q  <= buf_valid_d;
            last_grant_q <= last_grant_d;
            for (int i = 0; i < 3; i++) begin
                buf_wnum_q[i]  <= buf_wnum_d[i];
                buf_wdata_q[i] <= buf_wdata_d[i];
            end
        end
    end

endmodule
